// File: rtl/chip8_fetch_ctrl.sv
// CHIP-8 instruction fetch sequencer: owns the PC, issues two byte reads per opcode,
// assembles them big-endian and hands the opcode to execute over valid/ready.
module chip8_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] PC_RESET = 'h200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic [15:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              jump_valid_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              skip_i,
  output logic [3:0]        op_o,
  output logic [3:0]        x_o,
  output logic [3:0]        y_o,
  output logic [3:0]        n_o,
  output logic [7:0]        nn_o,
  output logic [11:0]       nnn_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRdHi  = 3'd1;
  localparam logic [2:0] StRdLo  = 3'd2;
  localparam logic [2:0] StCapLo = 3'd3;
  localparam logic [2:0] StValid = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;

  logic [ADDR_W-1:0] pc_inc1;
  logic [ADDR_W-1:0] pc_step;

  // All PC arithmetic wraps naturally at ADDR_W bits.
  assign pc_inc1 = pc_q + ADDR_W'(1);
  assign pc_step = pc_q + (skip_i ? ADDR_W'(4) : ADDR_W'(2));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    mem_rd_o      = 1'b0;
    mem_addr_o    = pc_q;
    instr_valid_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (!halt_i) state_d = StRdHi;
      end
      StRdHi: begin
        mem_rd_o = 1'b1;
        state_d  = StRdLo;
      end
      StRdLo: begin
        mem_rd_o         = 1'b1;
        mem_addr_o       = pc_inc1;
        instr_d[15:8]    = mem_rdata_i;
        state_d          = StCapLo;
      end
      StCapLo: begin
        instr_d[7:0] = mem_rdata_i;
        state_d      = StValid;
      end
      StValid: begin
        instr_valid_o = 1'b1;
        // Redirects are only meaningful at the handshake; jump beats skip.
        if (instr_ready_i) begin
          pc_d    = jump_valid_i ? jump_addr_i : pc_step;
          state_d = halt_i ? StIdle : StRdHi;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= PC_RESET;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign instr_o    = instr_q;
  assign instr_pc_o = pc_q;
  assign op_o       = instr_q[15:12];
  assign x_o        = instr_q[11:8];
  assign y_o        = instr_q[7:4];
  assign n_o        = instr_q[3:0];
  assign nn_o       = instr_q[7:0];
  assign nnn_o      = instr_q[11:0];

endmodule

// File: tb/tb_chip8_fetch_ctrl.sv
// Bench for chip8_fetch_ctrl: random redirect/halt/ready traffic against a PC-sequence
// model, with a scoreboard monitor checking every handed-off opcode.
module tb_chip8_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_valid;
  logic [11:0] jump_addr;
  logic        skip;
  logic [3:0]  op, x, y, n;
  logic [7:0]  nn;
  logic [11:0] nnn;

  chip8_fetch_ctrl #(.ADDR_W(12), .PC_RESET(12'h200)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .halt_i       (halt),
    .mem_rd_o     (mem_rd),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .jump_valid_i (jump_valid),
    .jump_addr_i  (jump_addr),
    .skip_i       (skip),
    .op_o         (op),
    .x_o          (x),
    .y_o          (y),
    .n_o          (n),
    .nn_o         (nn),
    .nnn_o        (nnn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous byte-wide program memory.
  logic [7:0] mem [4096];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic [11:0] pc;
    logic [15:0] ins;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pc_m;
  int   rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model of the PC rule at a handshake; pushes the opcode expected next.
  task automatic push_next();
    int np;
    if (jump_valid) np = int'(jump_addr);
    else np = (pc_m + (skip ? 4 : 2)) % 4096;
    pc_m = np;
    q.push_back('{pc: np[11:0], ins: {mem[np], mem[(np + 1) % 4096]}});
  endtask

  task automatic push_reset();
    q.delete();
    pc_m = 'h200;
    q.push_back('{pc: 12'h200, ins: {mem['h200], mem['h201]}});
  endtask

  task automatic wait_valid(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (instr_valid) break;
      @(negedge clk);
      #2;
    end
    chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  // Monitor: pops and compares on every handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        rd_cnt = 0;
      end else begin
        if (mem_rd) rd_cnt++;
        if (instr_valid) chk("rd_during_valid", {31'd0, mem_rd}, 32'd0);
        if (instr_valid && instr_ready) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty: got instr %0h pc %0h, expected nothing", instr,
                     instr_pc);
          end else begin
            e = q.pop_front();
            chk("instr", {16'd0, instr}, {16'd0, e.ins});
            chk("instr_pc", {20'd0, instr_pc}, {20'd0, e.pc});
            chk("fields", {16'd0, op, x, y, n}, {16'd0, e.ins});
            chk("nn_nnn", {12'd0, nn, nnn}, {12'd0, e.ins[7:0], e.ins[11:0]});
            chk("reads_per_instr", rd_cnt, 2);
          end
          rd_cnt = 0;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem['h200] = 8'h12;
    mem['h201] = 8'h34;
    rst_n = 1'b1; halt = 1'b0; instr_ready = 1'b0;
    jump_valid = 1'b0; jump_addr = '0; skip = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'h0);
    chk("rst_pc", {20'd0, instr_pc}, 32'h200);
    push_reset();

    // Release reset and trace the first fetch cycle by cycle.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #2;
      chk("lat_mem_rd", {31'd0, mem_rd}, (k == 1 || k == 2) ? 32'd1 : 32'd0);
      if (k <= 2) chk("lat_mem_addr", {20'd0, mem_addr}, (k == 1) ? 32'h200 : 32'h201);
      chk("lat_valid", {31'd0, instr_valid}, (k == 4) ? 32'd1 : 32'd0);
    end

    // Stall in VALID: output must hold.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #2;
      chk("stall_instr", {16'd0, instr}, 32'h1234);
      chk("stall_pc", {20'd0, instr_pc}, 32'h200);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end

    // Random traffic: ready, redirects and halt all toggled every cycle.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      instr_ready = ($urandom % 4) != 0;
      jump_valid  = ($urandom % 6) == 0;
      if ($urandom % 6 == 0) jump_addr = ($urandom % 2) ? 12'hFFF : 12'hFFE;
      else jump_addr = 12'($urandom);
      skip = 1'($urandom);
      halt = ($urandom % 8) == 0;
      if (instr_valid && instr_ready) push_next();
    end

    // Halt raised mid-fetch: fetch completes, then the block idles.
    @(negedge clk);
    instr_ready = 1'b0; jump_valid = 1'b0; skip = 1'b0; halt = 1'b0;
    #2 wait_valid(20);
    instr_ready = 1'b1;
    push_next();
    @(negedge clk);
    instr_ready = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    #2 wait_valid(10);
    instr_ready = 1'b1;
    push_next();
    @(negedge clk);
    instr_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk("halt_mem_rd", {31'd0, mem_rd}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    halt = 1'b0;
    #2 wait_valid(10);

    // Reset while the low byte is being read.
    instr_ready = 1'b1;
    push_next();
    @(negedge clk);
    instr_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_instr", {16'd0, instr}, 32'h0);
    chk("midrst_pc", {20'd0, instr_pc}, 32'h200);
    push_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2 wait_valid(10);
    chk("refetch_instr", {16'd0, instr}, 32'h1234);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
